// File: rtl/umi_tx_arb_fifo.sv
// umi_tx_arb_fifo: N per-channel UMI request FIFOs merged onto one registered
// UMI output through a round-robin or fixed-priority arbiter.
module umi_tx_arb_fifo #(
    parameter int unsigned N     = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 256,
    parameter int unsigned AW    = 64,
    parameter int unsigned CW    = 32,
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            arb_mode,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*CW-1:0] in_cmd,
    input  logic [N*AW-1:0] in_dstaddr,
    input  logic [N*AW-1:0] in_srcaddr,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_cmd,
    output logic [AW-1:0]   out_dstaddr,
    output logic [AW-1:0]   out_srcaddr,
    output logic [DW-1:0]   out_data,
    output logic [N*LW-1:0] fifo_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = CW + 2 * AW + DW;

    logic [BW-1:0] mem      [N][DEPTH];
    logic [BW-1:0] in_beat  [N];
    logic [PW-1:0] wptr     [N];
    logic [PW-1:0] rptr     [N];
    logic [LW-1:0] level    [N];
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic [N-1:0]  nonempty;
    logic [GW-1:0] ptr;
    logic [GW-1:0] gnt;
    logic [GW-1:0] cand;
    logic          gnt_vld;
    logic          load;
    logic [BW-1:0] head;

    // Per-channel status; ready depends on FIFO state only, never on valid/out_ready.
    always_comb begin
        in_ready   = '0;
        nonempty   = '0;
        push       = '0;
        fifo_level = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i]             = (level[i] != LW'(DEPTH));
            nonempty[i]             = (level[i] != '0);
            push[i]                 = in_valid[i] & in_ready[i];
            fifo_level[i*LW +: LW]  = level[i];
            in_beat[i] = {in_cmd[i*CW +: CW], in_dstaddr[i*AW +: AW],
                          in_srcaddr[i*AW +: AW], in_data[i*DW +: DW]};
        end
    end

    // Arbiter: descending loops so the first channel in search order is assigned last.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        if (arb_mode || (N == 1)) begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                if (nonempty[k]) begin
                    gnt     = GW'(k);
                    gnt_vld = 1'b1;
                end
            end
        end else begin
            for (int k = int'(N); k >= 1; k--) begin
                cand = GW'((int'(ptr) + k) % int'(N));
                if (nonempty[cand]) begin
                    gnt     = cand;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    // Output register may take a new beat when empty or being drained this cycle.
    always_comb begin
        load = !out_valid || out_ready;
        pop  = '0;
        if (load && gnt_vld) begin
            pop[gnt] = 1'b1;
        end
        head = mem[gnt][rptr[gnt]];
    end

    // FIFO pointers and occupancy; a full FIFO never accepts, even when popping.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + PW'(1);
                if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
                level[i] <= level[i] + LW'(push[i]) - LW'(pop[i]);
            end
        end
    end

    // FIFO storage; contents are qualified by level, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) mem[i][wptr[i]] <= in_beat[i];
        end
    end

    // Registered output stage and round-robin pointer (updated on every grant).
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid   <= 1'b0;
            out_cmd     <= '0;
            out_dstaddr <= '0;
            out_srcaddr <= '0;
            out_data    <= '0;
            ptr         <= GW'(N - 1);
        end else if (load) begin
            if (gnt_vld) begin
                out_valid <= 1'b1;
                {out_cmd, out_dstaddr, out_srcaddr, out_data} <= head;
                ptr       <= gnt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_umi_tx_arb_fifo.sv
// tb_umi_tx_arb_fifo: directed and random checks of umi_tx_arb_fifo against a
// queue-based transaction model.
module tb_umi_tx_arb_fifo;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 256;
    localparam int AW    = 64;
    localparam int CW    = 32;
    localparam int LW    = 3;
    localparam int BW    = CW + 2 * AW + DW;

    typedef logic [BW-1:0] beat_t;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic            mode = 1'b0;
    logic [N-1:0]    vld = '0;
    logic            ordy = 1'b0;
    logic [N-1:0]    in_ready;
    logic [N*CW-1:0] in_cmd;
    logic [N*AW-1:0] in_dstaddr;
    logic [N*AW-1:0] in_srcaddr;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic [CW-1:0]   out_cmd;
    logic [AW-1:0]   out_dstaddr;
    logic [AW-1:0]   out_srcaddr;
    logic [DW-1:0]   out_data;
    logic [N*LW-1:0] fifo_level;

    beat_t drv [N];

    // Reference model state
    beat_t mq [N][$];
    logic  mv;
    beat_t mb;
    int    mptr;
    int    acc [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_map
        assign in_cmd[i*CW +: CW]     = drv[i][BW-1 -: CW];
        assign in_dstaddr[i*AW +: AW] = drv[i][DW+AW +: AW];
        assign in_srcaddr[i*AW +: AW] = drv[i][DW +: AW];
        assign in_data[i*DW +: DW]    = drv[i][0 +: DW];
    end

    umi_tx_arb_fifo #(
        .N(N), .DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .arb_mode   (mode),
        .in_valid   (vld),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_dstaddr (in_dstaddr),
        .in_srcaddr (in_srcaddr),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (ordy),
        .out_cmd    (out_cmd),
        .out_dstaddr(out_dstaddr),
        .out_srcaddr(out_srcaddr),
        .out_data   (out_data),
        .fifo_level (fifo_level)
    );

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat(input int ch);
        beat_t b;
        for (int w = 0; w < BW / 32; w++) b[w*32 +: 32] = $urandom;
        b[BW-CW +: 8] = 8'(ch);
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mq[i].delete();
        mv   = 1'b0;
        mb   = '0;
        mptr = N - 1;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int   g;
        logic ld;
        logic pushed [N];
        @(posedge clk);
        for (int i = 0; i < N; i++) pushed[i] = vld[i] && (mq[i].size() < DEPTH);
        ld = !mv || ordy;
        if (ld) begin
            g = -1;
            if (mode) begin
                for (int i = 0; i < N; i++) if (g < 0 && mq[i].size() > 0) g = i;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (mptr + k) % N;
                    if (g < 0 && mq[c].size() > 0) g = c;
                end
            end
            if (g >= 0) begin
                mb   = mq[g].pop_front();
                mv   = 1'b1;
                mptr = g;
            end else begin
                mv = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pushed[i]) begin
                mq[i].push_back(drv[i]);
                acc[i]++;
            end
        end
        #1;
        check("out_valid", out_valid, mv);
        if (mv) check("out_beat", {out_cmd, out_dstaddr, out_srcaddr, out_data}, mb);
        for (int i = 0; i < N; i++) begin
            check("in_ready", in_ready[i], mq[i].size() < DEPTH);
            check("fifo_level", fifo_level[i*LW +: LW], mq[i].size());
        end
    endtask

    task automatic do_reset();
        vld  = '0;
        ordy = 1'b0;
        mode = 1'b0;
        #1 nreset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 2'b11);
        check("rst_level", fifo_level, 0);
        model_clear();
        @(negedge clk) nreset = 1'b1;
    endtask

    initial begin
        int st [N];
        int nout;
        int guard;
        logic seen1;
        logic order_err;

        for (int i = 0; i < N; i++) begin
            drv[i] = '0;
            acc[i] = 0;
        end
        model_clear();

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 2'b11);
        check("rst_level", fifo_level, 0);
        check("rst_out_beat", {out_cmd, out_dstaddr, out_srcaddr, out_data}, 0);
        @(negedge clk) nreset = 1'b1;
        for (int c = 0; c < 5; c++) step();

        // Single beat on ch1
        drv[1] = {32'h4, 64'h0, 64'h0, 256'hA5};
        vld    = 2'b10;
        ordy   = 1'b1;
        step();
        vld = '0;
        step();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 256'hA5);
        check("single_cmd", out_cmd, 32'h4);
        step();
        check("single_gone", out_valid, 0);

        // Fill ch0 with the output stalled, then drain
        ordy = 1'b0;
        vld  = 2'b01;
        st[0] = acc[0];
        guard = 0;
        while (acc[0] - st[0] < 5 && guard < 20) begin
            drv[0] = rand_beat(0);
            step();
            guard++;
        end
        check("fill_accepted", acc[0] - st[0], 5);
        check("fill_level", fifo_level[LW-1:0], 4);
        check("fill_ready", in_ready[0], 0);
        vld  = '0;
        ordy = 1'b1;
        for (int c = 0; c < 7; c++) step();
        check("fill_drained", fifo_level, 0);

        // Round-robin alternation
        do_reset();
        ordy = 1'b1;
        for (int i = 0; i < N; i++) st[i] = acc[i];
        nout  = 0;
        guard = 0;
        while (nout < 16 && guard < 100) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = (acc[i] - st[i] < 8);
                drv[i] = rand_beat(i);
            end
            step();
            if (out_valid) begin
                check("rr_channel", out_cmd[7:0], nout % 2);
                nout++;
            end
            guard++;
        end
        check("rr_count", nout, 16);

        // Fixed priority
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < N; i++) st[i] = acc[i];
        guard = 0;
        while ((acc[0] - st[0] < 4 || acc[1] - st[1] < 4) && guard < 50) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = (acc[i] - st[i] < 4);
                drv[i] = rand_beat(i);
            end
            step();
            guard++;
        end
        vld = '0;
        check("prio_first", out_cmd[7:0], 0);
        ordy      = 1'b1;
        nout      = 1;
        seen1     = 1'b0;
        order_err = 1'b0;
        guard     = 0;
        while (nout < 8 && guard < 50) begin
            step();
            if (out_valid) begin
                if (out_cmd[7:0] == 8'd1) seen1 = 1'b1;
                else if (seen1) order_err = 1'b1;
                nout++;
            end
            guard++;
        end
        check("prio_count", nout, 8);
        check("prio_order", order_err, 0);

        // Random stress
        do_reset();
        for (int i = 0; i < N; i++) st[i] = acc[i];
        guard = 0;
        while ((acc[0] - st[0] < 1000 || acc[1] - st[1] < 1000 || mv ||
                mq[0].size() > 0 || mq[1].size() > 0) && guard < 20000) begin
            for (int i = 0; i < N; i++) begin
                vld[i] = ($urandom_range(1, 0) == 1) && (acc[i] - st[i] < 1000);
                drv[i] = rand_beat(i);
            end
            ordy = ($urandom_range(1, 0) == 1);
            if (guard % 64 == 0) mode = ($urandom_range(1, 0) == 1);
            step();
            guard++;
        end
        check("stress_done", guard < 20000, 1);

        // Reset in the middle of traffic
        vld  = 2'b11;
        ordy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) drv[i] = rand_beat(i);
            step();
        end
        check("mid_valid_before", out_valid, 1);
        do_reset();
        for (int c = 0; c < 3; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
